mul4_arbiter: RTL and testbench

- Round-robin scheduler that shares one 4-bit sequential multiplier (mul4) among NREQ requesters.
- Accepts one operand pair at a time and issues a one-cycle start pulse to mul4.
- Waits a fixed MUL_LAT cycles, because mul4 has no done flag, then captures the 8-bit product.
- Returns the product to the originating requester over a valid/ready response channel. Sits between client datapaths and the single mul4 instance.

---
 rtl/mul4_arbiter_if.sv | 34 +++
 rtl/mul4_arbiter.sv | 154 +++++++++++++++
 tb/tb_mul4_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul4_arbiter_if.sv
// Request/response channel bundle between NREQ client datapaths and
// mul4_arbiter.
//
// Handshake rules for both channels:
// - Request channel: a client holds req_valid[i] with its operands on
//   req_m/req_q[4i+3:4i]. The arbiter samples them only while idle. It
//   answers with a one-cycle req_ready[i] pulse, which is itself the
//   completion of the handshake. Requests are never queued.
// - Response channel: rsp_valid is one-hot and is held, together with a
//   stable rsp_data, until the selected client raises its rsp_ready bit.
//   The transfer happens on the rising edge where both are high.
interface mul4_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_m;
    logic [4*NREQ-1:0] req_q;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [7:0]        rsp_data;

    // Arbiter side.
    modport slave (
        input  req_valid, req_m, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

    // Client side.
    modport master (
        output req_valid, req_m, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mul4_arbiter.sv
// Round-robin scheduler that shares one 4-bit sequential multiplier (mul4)
// among NREQ requesters. mul4 has no done flag, so the result is captured a
// fixed MUL_LAT cycles after the start pulse.
//
// Optional feature, macro MUL4_ARB_BYPASS_EN: trivial operand pairs
// (either operand 0, or either operand 1) are answered without using mul4.
// The FSM still passes through ISSUE, but with mul_start suppressed, and
// then goes straight to RESP.
module mul4_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4,
    parameter int IDXW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    mul4_arbiter_if.slave   bus,
    output logic            mul_start,
    output logic [3:0]      mul_din_m,
    output logic [3:0]      mul_din_q,
    input  logic [7:0]      mul_d_out,
    output logic            busy,
    output logic [IDXW-1:0] grant_idx,
    output logic [1:0]      dbg_state
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic              byp_q;
    logic [NREQ-1:0]   req_ready_q;
    logic [7:0]        rsp_data_q;
    logic [NREQ-1:0]   rsp_onehot;

    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] req_rot;
    logic              any_req;
    logic [IDXW-1:0]   sel_idx;
    logic [3:0]        sel_m;
    logic [3:0]        sel_q;
    logic              byp_hit;
    logic [7:0]        byp_data;
    logic              wait_done;

    // Round-robin pick: rotate the doubled request vector so that bit 0 is
    // the requester just after the last grant, then take the lowest set bit.
    always_comb begin
        req_dbl = {bus.req_valid, bus.req_valid};
        req_rot = req_dbl >> (int'(grant_idx) + 1);
        any_req = 1'b0;
        sel_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                any_req = 1'b1;
                sel_idx = IDXW'((int'(grant_idx) + 1 + k) % NREQ);
            end
        end
        sel_m = 4'(bus.req_m >> (4 * int'(sel_idx)));
        sel_q = 4'(bus.req_q >> (4 * int'(sel_idx)));
    end

`ifdef MUL4_ARB_BYPASS_EN
    // Shortcut results for operand pairs whose product is known without mul4.
    always_comb begin
        byp_hit  = 1'b1;
        byp_data = '0;
        if (sel_m == 4'd0 || sel_q == 4'd0) begin
            byp_data = '0;
        end else if (sel_m == 4'd1) begin
            byp_data = {4'b0, sel_q};
        end else if (sel_q == 4'd1) begin
            byp_data = {4'b0, sel_m};
        end else begin
            byp_hit = 1'b0;
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
`endif

    assign wait_done  = (cnt == CW'(MUL_LAT - 1));
    assign rsp_onehot = NREQ'(1) << grant_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; RESP waits on the granted requester's rsp_ready only.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = byp_q ? RESP : WAIT;
            WAIT:    if (wait_done) state_next = RESP;
            RESP:    if ((bus.rsp_ready & rsp_onehot) != '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant bookkeeping, operand latch, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q <= '0;
            grant_idx   <= IDXW'(NREQ - 1);
            mul_din_m   <= '0;
            mul_din_q   <= '0;
            rsp_data_q  <= '0;
            cnt         <= '0;
            byp_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        req_ready_q <= NREQ'(1) << sel_idx;
                        grant_idx   <= sel_idx;
                        mul_din_m   <= sel_m;
                        mul_din_q   <= sel_q;
                        byp_q       <= byp_hit;
                        if (byp_hit) rsp_data_q <= byp_data;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (wait_done) rsp_data_q <= mul_d_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state == RESP) ? rsp_onehot : '0;
    assign bus.rsp_data  = rsp_data_q;
    assign mul_start     = (state == ISSUE) && !byp_q;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_mul4_arbiter.sv
// Directed + randomized bench for mul4_arbiter with a behavioural mul4 model.
// Expected responses and grants are queued when stimulus is driven and
// compared when the DUT produces them. Honours MUL4_ARB_BYPASS_EN.
module tb_mul4_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;
    localparam int IDXW    = 3;
`ifdef MUL4_ARB_BYPASS_EN
    localparam int BYP     = 1;
`else
    localparam int BYP     = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul4_arbiter_if #(.NREQ(NREQ)) bus ();

    logic            mul_start;
    logic [3:0]      mul_din_m;
    logic [3:0]      mul_din_q;
    logic [7:0]      mul_d_out;
    logic            busy;
    logic [IDXW-1:0] grant_idx;
    logic [1:0]      dbg_state;

    mul4_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mul_start (mul_start),
        .mul_din_m (mul_din_m),
        .mul_din_q (mul_din_q),
        .mul_d_out (mul_d_out),
        .busy      (busy),
        .grant_idx (grant_idx),
        .dbg_state (dbg_state)
    );

    // mul4 model: d_out is the product only in the cycle MUL_LAT cycles
    // after the start pulse, a junk value otherwise.
    int         k_cnt = 0;
    logic [7:0] prod  = '0;
    always @(posedge clk) begin
        if (mul_start) begin
            k_cnt <= 1;
            prod  <= mul_din_m * mul_din_q;
        end else if (k_cnt != 0 && k_cnt < 100) begin
            k_cnt <= k_cnt + 1;
        end
    end
    assign mul_d_out = (k_cnt == MUL_LAT) ? prod : 8'hEE;

    // ---------------- scoreboard ----------------
    logic [11:0]     exp_q[$];
    logic [NREQ-1:0] gnt_q[$];
    int n_checks = 0;
    int n_fails  = 0;
    int starts   = 0;
    int rsp_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Response monitor, sampled 1 time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (mul_start) starts++;
        if (!rst && bus.rsp_valid != '0) rsp_seen++;
        if (!rst && (bus.rsp_valid & bus.rsp_ready) != '0) begin
            if (exp_q.size() == 0)
                check("rsp_unexpected", {20'd0, bus.rsp_valid, bus.rsp_data}, 32'd0);
            else
                check("rsp", {20'd0, bus.rsp_valid, bus.rsp_data}, {20'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int idx, input logic [3:0] m, input logic [3:0] q);
        bus.req_m[4*idx +: 4] = m;
        bus.req_q[4*idx +: 4] = q;
    endtask

    task automatic push_req(input int idx, input logic [3:0] m, input logic [3:0] q);
        logic [NREQ-1:0] oh;
        logic [7:0]      p;
        oh = NREQ'(1) << idx;
        p  = 8'(int'(m) * int'(q));
        set_ops(idx, m, q);
        gnt_q.push_back(oh);
        exp_q.push_back({oh, p});
    endtask

    // Advance until all queued work has drained; checks grants as they appear.
    task automatic run_until_idle(input int budget, input bit rnd_ready);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rnd_ready) bus.rsp_ready = NREQ'($urandom_range(0, 15));
            if (bus.req_ready != '0) begin
                if (gnt_q.size() == 0)
                    check("grant_unexpected", 32'(bus.req_ready), 32'd0);
                else
                    check("grant", 32'(bus.req_ready), 32'(gnt_q.pop_front()));
                bus.req_valid = bus.req_valid & ~bus.req_ready;
            end
            if (exp_q.size() == 0 && gnt_q.size() == 0 && !busy && bus.req_valid == '0) break;
            n++;
            if (n >= budget) begin
                check("run_timeout", 32'(exp_q.size()) + 32'(gnt_q.size()) + 32'(busy)
                      + 32'(bus.req_valid != '0), 32'd0);
                exp_q.delete();
                gnt_q.delete();
                bus.req_valid = '0;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int idx;
        logic [3:0] m;
        logic [3:0] q;

        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b1111;
        bus.req_m     = '0;
        bus.req_q     = '0;
        set_ops(0, 4'd7, 4'd1);
        set_ops(1, 4'd10, 4'd15);
        set_ops(2, 4'd15, 4'd15);
        set_ops(3, 4'd3, 4'd5);

        // Reset with all requests held.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_din_m",     32'(mul_din_m), 32'd0);
        check("rst_din_q",     32'(mul_din_q), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd3);
        check("rst_state",     32'(dbg_state), 32'd0);

        // Full contention: grants 0,1,2,3 with products 7,150,225,15.
        exp_q.push_back({4'b0001, 8'd7});
        exp_q.push_back({4'b0010, 8'd150});
        exp_q.push_back({4'b0100, 8'd225});
        exp_q.push_back({4'b1000, 8'd15});
        gnt_q.push_back(4'b0010);
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b1000);
        rst    = 1'b0;
        starts = 0;
        @(negedge clk);
        check("first_req_ready", 32'(bus.req_ready), 32'b0001);
        check("first_busy",      32'(busy), 32'd1);
        check("first_grant_idx", 32'(grant_idx), 32'd0);
        check("first_din_m",     32'(mul_din_m), 32'd7);
        check("first_din_q",     32'(mul_din_q), 32'd1);
        bus.req_valid[0] = 1'b0;
        run_until_idle(200, 1'b0);
        check("contention_starts", 32'(starts), 32'(4 - BYP));

        // Single request, latency check: req 0, 1*3.
        set_ops(0, 4'd1, 4'd3);
        bus.req_valid = 4'b0001;
        exp_q.push_back({4'b0001, 8'd3});
        starts = 0;
        @(negedge clk);
        check("single_req_ready", 32'(bus.req_ready), 32'b0001);
        check("single_mul_start", 32'(mul_start), 32'(1 - BYP));
        bus.req_valid = '0;
        for (int c = 2; c <= (BYP != 0 ? 2 : 2 + MUL_LAT); c++) begin
            @(negedge clk);
            check("single_rsp_valid", 32'(bus.rsp_valid),
                  (c == (BYP != 0 ? 2 : 2 + MUL_LAT)) ? 32'b0001 : 32'd0);
        end
        @(negedge clk);
        check("single_back_idle", 32'(busy), 32'd0);
        check("single_starts", 32'(starts), 32'(1 - BYP));

        // Backpressure on req 1: 10*15 held for 10 cycles.
        bus.rsp_ready = '0;
        set_ops(1, 4'd10, 4'd15);
        bus.req_valid = 4'b0010;
        exp_q.push_back({4'b0010, 8'd150});
        @(negedge clk);
        check("bp_req_ready", 32'(bus.req_ready), 32'b0010);
        bus.req_valid = '0;
        n = 0;
        while (bus.rsp_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_resp", 32'(bus.rsp_valid), 32'b0010);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
            check("bp_rsp_data",  32'(bus.rsp_data), 32'd150);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_busy",      32'(busy), 32'd1);
        end
        bus.rsp_ready = 4'b1111;
        bus.req_valid = '0;
        @(negedge clk);
        check("bp_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_done_busy",      32'(busy), 32'd0);
        check("bp_done_drained",   32'(exp_q.size()), 32'd0);

        // Randomized single requests with random response backpressure.
        for (int it = 0; it < 10; it++) begin
            idx = $urandom_range(0, NREQ - 1);
            m   = 4'($urandom_range(0, 15));
            q   = 4'($urandom_range(0, 15));
            push_req(idx, m, q);
            bus.req_valid = NREQ'(1) << idx;
            run_until_idle(100, 1'b1);
            bus.rsp_ready = 4'b1111;
        end

        // Reset during the second WAIT cycle abandons the transaction.
        set_ops(3, 4'd3, 4'd5);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        check("abort_req_ready", 32'(bus.req_ready), 32'b1000);
        bus.req_valid = '0;
        @(negedge clk);
        check("abort_wait1", 32'(dbg_state), 32'd2);
        @(negedge clk);
        check("abort_wait2", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state",     32'(dbg_state), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_busy",      32'(busy), 32'd0);
        check("abort_grant_idx", 32'(grant_idx), 32'd3);
        check("abort_rsp_data",  32'(bus.rsp_data), 32'd0);
        rsp_seen = 0;
        repeat (12) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_seen), 32'd0);

        // Zero operand on req 2.
        push_req(2, 4'd0, 4'd9);
        bus.req_valid = 4'b0100;
        starts = 0;
        run_until_idle(50, 1'b0);
        check("zero_starts", 32'(starts), 32'(1 - BYP));

        @(negedge clk);
        check("final_drained", 32'(exp_q.size()) + 32'(gnt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
